// File: rtl/rgb_pwm_driver.sv
// Double-buffered 3-channel active-low PWM driver for the iceBlinkPico RGB LED.
// Optional build macro RGB_PWM_GAMMA_EN applies gamma correction at the period-boundary load.
module rgb_pwm_driver #(
  parameter int PWM_BITS = 8,
  parameter int PRESCALE = 48
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [PWM_BITS-1:0] in_r,
  input  logic [PWM_BITS-1:0] in_g,
  input  logic [PWM_BITS-1:0] in_b,
  output logic                RGB_R,
  output logic                RGB_G,
  output logic                RGB_B,
  output logic                period_start
);

  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

  // Maps a raw intensity to the duty actually used for a period.
  function automatic logic [PWM_BITS-1:0] duty_map(input logic [PWM_BITS-1:0] v);
`ifdef RGB_PWM_GAMMA_EN
    logic [2*PWM_BITS-1:0] sq;
    // Max (2^n-1)^2 + 2^n-1 = 2^2n - 2^n, so the 2n-bit sum never overflows.
    sq = ({{PWM_BITS{1'b0}}, v} * {{PWM_BITS{1'b0}}, v})
       + {{PWM_BITS{1'b0}}, {PWM_BITS{1'b1}}};
    duty_map = sq[2*PWM_BITS-1:PWM_BITS];
`else
    duty_map = v;
`endif
  endfunction

  logic [PRE_W-1:0]    pre_r;
  logic [PWM_BITS-1:0] phase_r;
  logic [PWM_BITS-1:0] act_red_r, act_grn_r, act_blu_r;
  logic [PWM_BITS-1:0] shd_red_r, shd_grn_r, shd_blu_r;
  logic                pending_r;
  logic                wrap_d_r;
  logic                tick_s;
  logic                wrap_s;
  logic                accept_s;

  // Prescale tick, period wrap and handshake decode.
  always_comb begin
    tick_s   = (pre_r == PRE_LAST);
    wrap_s   = tick_s && (phase_r == {PWM_BITS{1'b1}});
    in_ready = ~pending_r & ~rst;
    accept_s = in_valid && in_ready;
  end

  // Counters, double buffer and registered LED / period_start outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_r        <= {PRE_W{1'b0}};
      phase_r      <= {PWM_BITS{1'b0}};
      act_red_r    <= {PWM_BITS{1'b0}};
      act_grn_r    <= {PWM_BITS{1'b0}};
      act_blu_r    <= {PWM_BITS{1'b0}};
      shd_red_r    <= {PWM_BITS{1'b0}};
      shd_grn_r    <= {PWM_BITS{1'b0}};
      shd_blu_r    <= {PWM_BITS{1'b0}};
      pending_r    <= 1'b0;
      wrap_d_r     <= 1'b0;
      period_start <= 1'b0;
      RGB_R        <= 1'b1;
      RGB_G        <= 1'b1;
      RGB_B        <= 1'b1;
    end else begin
      if (tick_s) begin
        pre_r   <= {PRE_W{1'b0}};
        phase_r <= phase_r + {{(PWM_BITS-1){1'b0}}, 1'b1};
      end else begin
        pre_r   <= pre_r + {{(PRE_W-1){1'b0}}, 1'b1};
      end

      if (wrap_s && pending_r) begin
        act_red_r <= duty_map(shd_red_r);
        act_grn_r <= duty_map(shd_grn_r);
        act_blu_r <= duty_map(shd_blu_r);
      end

      // Accept and boundary load are mutually exclusive: accept needs pending low.
      if (accept_s) begin
        shd_red_r <= in_r;
        shd_grn_r <= in_g;
        shd_blu_r <= in_b;
        pending_r <= 1'b1;
      end else if (wrap_s) begin
        pending_r <= 1'b0;
      end

      RGB_R        <= ~(enable && (phase_r < act_red_r));
      RGB_G        <= ~(enable && (phase_r < act_grn_r));
      RGB_B        <= ~(enable && (phase_r < act_blu_r));
      wrap_d_r     <= wrap_s;
      period_start <= wrap_d_r;
    end
  end

endmodule

// File: doc/rgb_pwm_driver.md
Name: rgb_pwm_driver

Overview:
- Downstream output stage for the on-board RGB LED of the iceBlinkPico.
- Accepts 8-bit per-channel intensity words from a color-sequencing stage over a valid/ready handshake, double-buffers them, and produces glitch-free PWM on the active-low RGB_R/RGB_G/RGB_B pins.
- New intensities take effect only at PWM period boundaries.

Parameters:
PWM_BITS, 8, duty/phase width; period = 2^PWM_BITS ticks
PRESCALE, 48, clk cycles per PWM tick; at 12 MHz: 250 kHz tick, ~977 Hz period; legal range >= 1

Ports:
clk  input  1  system clock, 12 MHz
rst  input  1  synchronous, active-high reset
enable  input  1  1 = drive LED, 0 = force all channels off
in_valid  input  1  upstream word valid
in_ready  output  1  driver can accept a word
in_r  input  PWM_BITS  red intensity, 0 = off
in_g  input  PWM_BITS  green intensity
in_b  input  PWM_BITS  blue intensity
RGB_R  output  1  red LED, active-low, registered
RGB_G  output  1  green LED, active-low, registered
RGB_B  output  1  blue LED, active-low, registered
period_start  output  1  one-cycle pulse marking the first output cycle of each PWM period

Behaviour:
- Reset (rst high at posedge):
  - Prescale counter, phase, active duties, shadow duties, pending and period_start pipeline all 0.
  - RGB_R/G/B = 1 (off); period_start = 0.
  - in_ready = ~pending & ~rst: low during reset cycles, 1 afterwards.
- Prescaler: pre counts 0..PRESCALE-1 and wraps. tick = (pre == PRESCALE-1). PRESCALE=1 gives tick every cycle.
- Phase: PWM_BITS-bit counter, increments on tick, wraps 2^PWM_BITS-1 -> 0. wrap = tick && phase == all-ones.
- Handshake:
  - Accept when in_valid && in_ready: shadow <= {in_r, in_g, in_b}, pending <= 1.
  - in_valid with in_ready low is ignored; upstream holds its word.
  - in_ready is derived from registered pending, so back-to-back accepts are impossible.
- Boundary load: on wrap with pending = 1, active <= shadow and pending <= 0.
  - in_ready rises the following cycle.
  - No accept is possible on a wrap cycle while pending = 1.
  - Wrap with pending = 0 leaves active unchanged.
- Output: each cycle, RGB_x <= ~(enable && phase < active_x), one cycle registered latency.
  - Duty 0: never on.
  - Duty 255: on 255/256 ticks; full-on is not supported.
- period_start: wrap delayed two cycles.
  - If wrap occurs at cycle T, phase = 0 and active = new at T+1.
  - Outputs for phase 0 and period_start = 1 both appear at T+2.
- enable = 0: outputs go to 1 on the next clock. Prescaler, phase, handshake and period_start keep running. Re-enable resumes mid-period with no resynchronization.
- Reset mid-operation: a discarded pending word is lost. The first period after reset starts with duties 0.
- Widths: comparison is unsigned PWM_BITS. No arithmetic overflow is possible except counter wraps as specified.

Optional Feature:
- Macro RGB_PWM_GAMMA_EN.
- Defined: the value loaded into active is gamma-corrected per channel: duty = (v*v + 2^PWM_BITS - 1) >> PWM_BITS.
  - Computed combinationally at the boundary load; the shadow stores raw v.
  - For 8 bits: 0->0, 1->1, 128->64, 255->255.
- Undefined: duty = v unchanged.
- Handshake, timing and latency are identical in both builds.

Test Plan:
- Reset: hold rst 3 cycles, release -> RGB_R/G/B = 1, period_start = 0, in_ready = 1 the first cycle after release.
- Basic PWM (PRESCALE=1): send r=128, g=0, b=255, enable=1. Then, within each 256-cycle window starting at the period_start after the load:
  - RGB_R = 0 for exactly the first 128 cycles.
  - RGB_G = 1 always.
  - RGB_B = 0 for 255 cycles and 1 in the last cycle.
  - period_start pulses every 256 cycles.
- Backpressure: send A = (10, 20, 30), then immediately hold B = (40, 50, 60) valid -> in_ready = 0 until the cycle after the next wrap. A is active in period N+1; B is accepted then and active in period N+2.
- Mid-period update: while active r = 200, accept r = 5 at phase 100 -> RGB_R stays at 200/256 for the rest of the current period and switches to 5/256 exactly at the next period_start.
- enable toggle: drop enable at phase 50 -> all outputs 1 on the next cycle. period_start spacing stays 256·PRESCALE cycles. Raise enable -> outputs follow phase < duty the next cycle.
- Reset mid-period with pending word: assert rst for 1 cycle -> outputs 1, in_ready = 1 after release, duties 0 (LED dark) until a new word is loaded at a boundary. With RGB_PWM_GAMMA_EN, repeat the basic-PWM scenario with r=128 -> RGB_R low for 64 cycles per period.
